// File: rtl/counter_sequencer_if.sv
// Handshake, config and counter-side bundle for counter_sequencer.
// When SEQ_WATCHDOG_EN is defined, the bundle also carries the err pulse.
interface counter_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] cfg_start;
  logic [WIDTH-1:0] cfg_end;
  logic             cfg_dir;
  logic [REP_W-1:0] cfg_repeat;
  logic [WIDTH-1:0] q_in;
  logic             sel;
  logic             up_and_down;
  logic [WIDTH-1:0] d_out;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pass_cnt;
`ifdef SEQ_WATCHDOG_EN
  logic             err;

  modport master (
    output start, abort, cfg_start, cfg_end, cfg_dir, cfg_repeat, q_in,
    input  sel, up_and_down, d_out, busy, done, pass_cnt, err
  );
  modport slave (
    input  start, abort, cfg_start, cfg_end, cfg_dir, cfg_repeat, q_in,
    output sel, up_and_down, d_out, busy, done, pass_cnt, err
  );
`else
  modport master (
    output start, abort, cfg_start, cfg_end, cfg_dir, cfg_repeat, q_in,
    input  sel, up_and_down, d_out, busy, done, pass_cnt
  );
  modport slave (
    input  start, abort, cfg_start, cfg_end, cfg_dir, cfg_repeat, q_in,
    output sel, up_and_down, d_out, busy, done, pass_cnt
  );
`endif
endinterface

// File: rtl/counter_sequencer.sv
// Drives a loadable up/down counter through N load/count passes with start/busy/done handshake.
// Optional SEQ_WATCHDOG_EN adds a RUN-cycle watchdog that pulses err on a stuck counter.
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input logic               clk,
  input logic               reset,
  counter_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_r, end_r;
  logic             dir_r;
  logic [REP_W-1:0] repeat_r, pass_cnt_q;

  logic             sel, up_and_down;
  logic [WIDTH-1:0] d_out;
  logic             latch_cfg, pass_step;

  logic             at_end, last_pass;
  logic [REP_W-1:0] pass_inc, pass_goal;

  assign at_end    = (bus.q_in == end_r);
  assign pass_inc  = pass_cnt_q + 1'b1;
  assign pass_goal = (repeat_r == '0) ? REP_W'(1) : repeat_r;
  assign last_pass = (pass_inc >= pass_goal);

`ifdef SEQ_WATCHDOG_EN
  // Longest legal pass spends 2^WIDTH cycles in RUN; the cycle after that trips.
  localparam logic [WIDTH:0] RUN_LIMIT = {1'b1, {WIDTH{1'b0}}};
  logic [WIDTH:0] run_cnt;
  logic           wd_trip;
  logic           err_q;
`endif

  always_comb begin
    state_d     = state_q;
    sel         = 1'b1;
    d_out       = bus.q_in;
    up_and_down = 1'b0;
    latch_cfg   = 1'b0;
    pass_step   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wd_trip     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch_cfg = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          d_out   = start_r;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins over a completing pass: no pass_cnt step, no done
        if (bus.abort) begin
          state_d = IDLE;
        end else if (at_end) begin
          pass_step = 1'b1;
          state_d   = last_pass ? DONE : LOAD;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (run_cnt == RUN_LIMIT) begin
          wd_trip = 1'b1;
          state_d = IDLE;
        end
`endif
        else begin
          sel         = 1'b0;
          up_and_down = dir_r;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_r    <= '0;
      end_r      <= '0;
      dir_r      <= 1'b0;
      repeat_r   <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_cfg) begin
        start_r    <= bus.cfg_start;
        end_r      <= bus.cfg_end;
        dir_r      <= bus.cfg_dir;
        repeat_r   <= bus.cfg_repeat;
        pass_cnt_q <= '0;
      end else if (pass_step) begin
        pass_cnt_q <= pass_inc;
      end
    end
  end

`ifdef SEQ_WATCHDOG_EN
  // run_cnt sits at zero outside RUN, so every entry to RUN starts a fresh count
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      run_cnt <= (state_q == RUN) ? run_cnt + 1'b1 : '0;
      err_q   <= wd_trip;
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.sel         = sel;
  assign bus.up_and_down = up_and_down;
  assign bus.d_out       = d_out;
  assign bus.busy        = (state_q == LOAD) || (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.pass_cnt    = pass_cnt_q;
endmodule
